// File: rtl/set_reset_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : set_reset_driver_pkg
// Description : Shared state encoding and default timing constants for the
//               counted set/reset latch and its driver.
// Revision    : 1.0 - initial release
// ============================================================================
package set_reset_driver_pkg;

    // Driver state encoding, shared with the latch side.
    typedef enum logic [0:0] {
        ARMED   = 1'b0,
        HOLDOFF = 1'b1
    } drv_state_t;

    localparam int          c_default_sync_stages = 2;
    localparam logic [15:0] c_default_holdoff     = 16'd100;
    localparam logic [15:0] c_default_release     = 16'd1000;

    // Increment that sticks at the given limit.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value,
                                              input logic [15:0] limit);
        return (value >= limit) ? limit : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Multi-flop synchronizer for an asynchronous input with
//               polarity conditioning and a single-cycle rising-edge pulse.
//               Shared by the front-panel inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,     // at least 2
    parameter logic POLARITY    = 1'b1   // active level of async_in
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level_d;

    // Synchronizer chain; resets to the inactive level so no false edge
    // appears when reset is released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{~POLARITY}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
        end
    end

    assign level = r_sync[SYNC_STAGES-1] ~^ POLARITY;

    // Previous conditioned level for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= level;
        end
    end

    assign rise = level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/set_reset_driver.sv
`default_nettype none
// ============================================================================
// Module      : set_reset_driver
// Description : Driver side of the counted set/reset latch. Issues
//               rate-limited set pulses while the sense condition is active
//               and a single reset pulse once a requested clear is allowed.
// Revision    : 1.0 - initial release
// ============================================================================
module set_reset_driver
    import set_reset_driver_pkg::*;
#(
    parameter int          SYNC_STAGES    = c_default_sync_stages,
    parameter logic        SENSE_POLARITY = 1'b1,
    parameter logic [15:0] HOLDOFF_CYCLES = c_default_holdoff,  // at least 1
    parameter logic [15:0] RELEASE_CYCLES = c_default_release,  // at least 1
    parameter int          COUNT_WIDTH    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sense_in,
    input  logic                   enable,
    input  logic                   clear_req,
    input  logic                   latched_q,
    output logic                   set_out,
    output logic                   reset_out,
    output logic [COUNT_WIDTH-1:0] pulse_count,
    output logic                   clear_pending,
    output logic                   overrun
);

    localparam logic [COUNT_WIDTH-1:0] c_count_max = '1;

    logic w_sense_s;
    logic w_rise;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .POLARITY    (SENSE_POLARITY)
    ) u_sense (
        .clock    (clock),
        .reset    (reset),
        .async_in (sense_in),
        .level    (w_sense_s),
        .rise     (w_rise)
    );

    drv_state_t              r_state;
    drv_state_t              w_state_next;
    logic [15:0]             r_holdoff;
    logic [15:0]             w_holdoff_next;
    logic [15:0]             r_release;
    logic [15:0]             w_release_next;
    logic                    w_set_next;
    logic                    w_reset_next;
    logic                    w_overrun_hit;
    logic                    r_set_out;
    logic                    r_reset_out;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic                    r_clear_pending;
    logic                    r_overrun;

    // State and holdoff counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ARMED;
            r_holdoff <= 16'd0;
        end else begin
            r_state   <= w_state_next;
            r_holdoff <= w_holdoff_next;
        end
    end

    // Next-state logic: first pulse on an edge, repeat pulses while the
    // level is held and the latch has not yet captured it.
    always_comb begin
        w_state_next   = r_state;
        w_holdoff_next = r_holdoff;
        w_set_next     = 1'b0;
        w_overrun_hit  = 1'b0;
        case (r_state)
            ARMED: begin
                if (w_rise && enable) begin
                    w_set_next     = 1'b1;
                    w_holdoff_next = HOLDOFF_CYCLES - 16'd1;
                    w_state_next   = HOLDOFF;
                end
            end
            HOLDOFF: begin
                w_overrun_hit = w_rise;
                if (r_holdoff == 16'd0) begin
                    if (w_sense_s && enable && !latched_q) begin
                        w_set_next     = 1'b1;
                        w_holdoff_next = HOLDOFF_CYCLES - 16'd1;
                    end else begin
                        w_state_next = ARMED;
                    end
                end else begin
                    w_holdoff_next = r_holdoff - 16'd1;
                end
            end
            default: begin
                w_state_next = ARMED;
            end
        endcase
    end

    // Quiet-time counter: consecutive inactive cycles, saturating.
    assign w_release_next = w_sense_s ? 16'd0 : sat_inc16(r_release, RELEASE_CYCLES);

    // A clear fires once the line has been quiet long enough. A set pulse in
    // the same cycle wins, and the cycle after a reset pulse is blocked so a
    // request is honoured with exactly one pulse.
    assign w_reset_next = r_clear_pending
                        && (w_release_next == RELEASE_CYCLES)
                        && !w_set_next
                        && !r_reset_out;

    // Output pulses, pulse counter, clear bookkeeping and sticky overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_release       <= 16'd0;
            r_set_out       <= 1'b0;
            r_reset_out     <= 1'b0;
            r_count         <= '0;
            r_clear_pending <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_release   <= w_release_next;
            r_set_out   <= w_set_next;
            r_reset_out <= w_reset_next;
            if (r_reset_out) begin
                // Clear takes effect the cycle after the reset pulse; a new
                // request in that same cycle stays pending.
                r_clear_pending <= clear_req;
                r_count         <= w_set_next ? {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : '0;
                r_overrun       <= w_overrun_hit;
            end else begin
                r_clear_pending <= r_clear_pending | clear_req;
                if (w_set_next && (r_count != c_count_max)) begin
                    r_count <= r_count + 1'b1;
                end
                r_overrun <= r_overrun | w_overrun_hit;
            end
        end
    end

    assign set_out       = r_set_out;
    assign reset_out     = r_reset_out;
    assign pulse_count   = r_count;
    assign clear_pending = r_clear_pending;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire
